// File: rtl/sort4_controller_pkg.sv
// Shared types and constants for the small batch sorter: FSM state encoding and data widths.
// Imported by the controller, the comparator and the bench so all three agree on the widths.
package sort4_controller_pkg;

  localparam int ELEM_W = 8;
  localparam int CNT_W  = 6;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_SORT = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

endpackage

// File: rtl/eight_bit_comparator.sv
// Unsigned 8-bit magnitude comparator with one-hot less/greater/equal flags; purely combinational.
// It has no handshake of its own, so it never applies backpressure.
module eight_bit_comparator
  import sort4_controller_pkg::*;
(
  input  logic [ELEM_W-1:0] a,
  input  logic [ELEM_W-1:0] b,
  output logic              l_out,
  output logic              g_out,
  output logic              e_out
);

  assign l_out = (a < b);
  assign g_out = (a > b);
  assign e_out = (a == b);

endmodule

// File: rtl/sort4_controller.sv
// Loads N bytes, bubble-sorts them in place at one compare per cycle (N-1 .. (N-1)^2 cycles), then streams them out in ascending order.
// in_ready is high only while loading; out_valid holds with stable data until out_ready.
module sort4_controller
  import sort4_controller_pkg::*;
#(
  parameter int N = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [ELEM_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [ELEM_W-1:0] out_data,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  cmp_count
);

  localparam int IDX_W = $clog2(N);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
  localparam logic [IDX_W-1:0] LAST_J   = IDX_W'(N - 2);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   wr_idx_q, wr_idx_d;
  logic [IDX_W-1:0]   rd_idx_q, rd_idx_d;
  logic [IDX_W-1:0]   j_q, j_d;
  logic [IDX_W-1:0]   pass_q, pass_d;
  logic               swapped_q, swapped_d;
  logic [CNT_W-1:0]   cmp_count_q, cmp_count_d;
  logic [ELEM_W-1:0]  mem_q [N];
  logic [ELEM_W-1:0]  mem_d [N];

  logic [IDX_W-1:0]   j_nxt;
  logic [ELEM_W-1:0]  cmp_a, cmp_b;
  logic               l_out, g_out, e_out;
  logic               pass_swapped;

  assign j_nxt        = j_q + IDX_W'(1);
  assign cmp_a        = mem_q[j_q];
  assign cmp_b        = mem_q[j_nxt];
  assign pass_swapped = swapped_q | g_out;

  eight_bit_comparator u_cmp (
    .a     (cmp_a),
    .b     (cmp_b),
    .l_out (l_out),
    .g_out (g_out),
    .e_out (e_out)
  );

  always_comb begin
    state_d     = state_q;
    wr_idx_d    = wr_idx_q;
    rd_idx_d    = rd_idx_q;
    j_d         = j_q;
    pass_d      = pass_q;
    swapped_d   = swapped_q;
    cmp_count_d = cmp_count_q;
    mem_d       = mem_q;
    case (state_q)
      ST_LOAD: begin
        if (in_valid) begin
          mem_d[wr_idx_q] = in_data;
          if (wr_idx_q == LAST_IDX) begin
            state_d     = ST_SORT;
            wr_idx_d    = '0;
            j_d         = '0;
            pass_d      = '0;
            swapped_d   = 1'b0;
            cmp_count_d = '0;
          end else begin
            wr_idx_d = wr_idx_q + IDX_W'(1);
          end
        end
      end
      ST_SORT: begin
        cmp_count_d = cmp_count_q + CNT_W'(1);
        // Swap only on strictly greater so equal keys keep their load order.
        if (g_out) begin
          mem_d[j_q]   = cmp_b;
          mem_d[j_nxt] = cmp_a;
        end
        if (j_q == LAST_J) begin
          if (!pass_swapped || (pass_q == LAST_J)) begin
            state_d  = ST_OUT;
            rd_idx_d = '0;
          end else begin
            j_d       = '0;
            pass_d    = pass_q + IDX_W'(1);
            swapped_d = 1'b0;
          end
        end else begin
          j_d       = j_nxt;
          swapped_d = pass_swapped;
        end
      end
      ST_OUT: begin
        if (out_ready) begin
          if (rd_idx_q == LAST_IDX) begin
            state_d  = ST_LOAD;
            rd_idx_d = '0;
            wr_idx_d = '0;
          end else begin
            rd_idx_d = rd_idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_LOAD;
      wr_idx_q    <= '0;
      rd_idx_q    <= '0;
      j_q         <= '0;
      pass_q      <= '0;
      swapped_q   <= 1'b0;
      cmp_count_q <= '0;
    end else begin
      state_q     <= state_d;
      wr_idx_q    <= wr_idx_d;
      rd_idx_q    <= rd_idx_d;
      j_q         <= j_d;
      pass_q      <= pass_d;
      swapped_q   <= swapped_d;
      cmp_count_q <= cmp_count_d;
    end
  end

  // Element storage carries no reset; contents are only meaningful after a full load.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign in_ready  = (state_q == ST_LOAD);
  assign out_valid = (state_q == ST_OUT);
  assign busy      = (state_q == ST_SORT);
  assign out_data  = mem_q[rd_idx_q];
  assign done      = (state_q == ST_OUT) && out_ready && (rd_idx_q == LAST_IDX);
  assign cmp_count = cmp_count_q;

endmodule

// File: tb/tb_sort4_controller.sv
// Directed-vector bench for sort4_controller with hand-computed sorted outputs and sort latencies.
module tb_sort4_controller;
  import sort4_controller_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [ELEM_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [ELEM_W-1:0] out_data;
  logic              out_ready;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  cmp_count;

  int n_vec = 0;
  int n_err = 0;

  sort4_controller #(.N(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done),
    .cmp_count (cmp_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load4(input logic [7:0] d0, d1, d2, d3);
    logic [7:0] d [4];
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    for (int i = 0; i < 4; i++) begin
      chk("in_ready_load", in_ready, 1);
      in_valid = 1'b1;
      in_data  = d[i];
      step();
    end
    in_valid = 1'b0;
  endtask

  // Counts SORT cycles; optionally keeps offering junk input to show it is ignored.
  task automatic wait_sort(input int exp_cyc, input bit poke);
    int cyc = 0;
    if (poke) begin
      in_valid = 1'b1;
      in_data  = 8'hEE;
    end
    while (busy && cyc < 100) begin
      if (cyc == 0) begin
        chk("in_ready_sort", in_ready, 0);
        chk("out_valid_sort", out_valid, 0);
      end
      step();
      cyc++;
    end
    in_valid = 1'b0;
    chk("busy_cycles", cyc, exp_cyc);
    chk("cmp_count", cmp_count, exp_cyc);
  endtask

  task automatic drain4(input logic [7:0] e0, e1, e2, e3, input int stall, input int exp_cnt);
    logic [7:0] e [4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    out_ready = 1'b0;
    for (int s = 0; s < stall; s++) begin
      chk("stall_valid", out_valid, 1);
      chk("stall_data", out_data, e[0]);
      chk("stall_done", done, 0);
      step();
    end
    for (int i = 0; i < 4; i++) begin
      out_ready = 1'b1;
      #1;
      chk("out_valid", out_valid, 1);
      chk("out_data", out_data, e[i]);
      chk("done", done, (i == 3) ? 1 : 0);
      step();
    end
    out_ready = 1'b0;
    chk("post_in_ready", in_ready, 1);
    chk("post_out_valid", out_valid, 0);
    chk("post_done", done, 0);
    chk("cmp_hold", cmp_count, exp_cnt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cmp_count", cmp_count, 0);
    rst = 1'b0;
    step();

    // Mixed values, consumer stalls 5 cycles on the first element.
    load4(8'd200, 8'd15, 8'd128, 8'd127);
    wait_sort(9, 1'b0);
    drain4(8'd15, 8'd127, 8'd128, 8'd200, 5, 9);

    // Already sorted, junk offered on the input while sorting.
    load4(8'd1, 8'd2, 8'd3, 8'd4);
    wait_sort(3, 1'b1);
    drain4(8'd1, 8'd2, 8'd3, 8'd4, 0, 3);

    // Reversed: worst case.
    load4(8'd4, 8'd3, 8'd2, 8'd1);
    wait_sort(9, 1'b0);
    drain4(8'd1, 8'd2, 8'd3, 8'd4, 0, 9);

    // Duplicates and extremes.
    load4(8'd25, 8'd25, 8'd0, 8'd255);
    wait_sort(9, 1'b0);
    drain4(8'd0, 8'd25, 8'd25, 8'd255, 0, 9);

    // Reset during the second SORT cycle discards the batch.
    load4(8'd9, 8'd8, 8'd7, 8'd6);
    chk("mid_busy", busy, 1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_cmp_count", cmp_count, 0);
    load4(8'd39, 8'd16, 8'd79, 8'd37);
    wait_sort(9, 1'b0);
    drain4(8'd16, 8'd37, 8'd39, 8'd79, 0, 9);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sort4_controller.md
SORT4_CONTROLLER -- requirements
Module: sort4_controller

Interface
REQ-001 SHALL have parameter N, 4, number of 8-bit elements per sort batch (legal 2..8).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-004 SHALL have port in_valid  input  1  element offered on in_data.
REQ-005 SHALL have port in_data  input  8  unsigned element to load.
REQ-006 SHALL have port in_ready  output  1  high only in LOAD state.
REQ-007 SHALL have port out_valid  output  1  high only in OUT state.
REQ-008 SHALL have port out_data  output  8  current sorted element, ascending order.
REQ-009 SHALL have port out_ready  input  1  consumer accepts out_data.
REQ-010 SHALL have port busy  output  1  high in SORT state.
REQ-011 SHALL have port done  output  1  one-cycle pulse when the last sorted element is accepted.
REQ-012 SHALL have port cmp_count  output  6  number of comparisons used by the last/current sort.

Function
REQ-013 SHALL implement states LOAD, SORT, OUT; reset state LOAD.
REQ-014 LOAD: an element SHALL be written to mem[wr_idx] on every cycle with in_valid && in_ready; wr_idx increments by 1.
REQ-015 When the N-th element is accepted, the next state SHALL be SORT with j=0, swapped flag=0, pass=0, cmp_count=0.
REQ-016 SORT: exactly one comparison per cycle, a=mem[j], b=mem[j+1], through one shared comparator; cmp_count +1 per cycle.
REQ-017 If comparator g_out=1, mem[j] and mem[j+1] SHALL swap at that clock edge and swapped flag SHALL set; on e_out or l_out there is no swap (stable sort).
REQ-018 j SHALL increment each cycle; at j=N-2 the pass ends.
REQ-019 At pass end: if no swap occurred in the pass (including the final compare) or pass=N-2, next state SHALL be OUT; else j=0, pass+1, swapped flag cleared.
REQ-020 Sort latency SHALL be N-1 cycles minimum (already sorted input) and (N-1)^2 cycles maximum; for N=4: 3..9 cycles.
REQ-021 OUT: out_data SHALL equal mem[rd_idx] combinationally; rd_idx increments on out_valid && out_ready.
REQ-022 Acceptance of element N-1 SHALL pulse done for that cycle and return to LOAD with wr_idx=rd_idx=0 next cycle.
REQ-023 out_valid SHALL stay high and out_data SHALL stay stable while out_ready=0 (no data dropped).
REQ-024 in_valid SHALL be ignored outside LOAD; out_ready SHALL be ignored outside OUT.
REQ-025 cmp_count SHALL hold its final value through OUT and LOAD until the next SORT entry clears it.
REQ-026 All values SHALL be treated as unsigned 8-bit (0..255); no width extension in mem.

Reset
REQ-027 rst=1 at a clock edge SHALL force LOAD, wr_idx=rd_idx=j=pass=0, cmp_count=0, swapped flag=0, regardless of state (including mid-SORT or mid-OUT).
REQ-028 During and after reset: in_ready=1 (once in LOAD), out_valid=0, busy=0, done=0, out_data=mem[0] (don't-care); mem contents SHALL not require reset.
REQ-029 A partially loaded or partially drained batch interrupted by reset SHALL be discarded.

Structure
REQ-030 State encoding (LOAD/SORT/OUT) and element width constant 8 SHALL live in a shared package used by controller and bench.
REQ-031 Comparison SHALL be performed by exactly one instance of the existing eight_bit_comparator (ports a, b, l_out, g_out, e_out); no other magnitude compare in the datapath.
REQ-032 Controller FSM, index counters and element register file SHALL be in sort4_controller; no further sub-modules.

Verification
REQ-033 Load 200,15,128,127 -> output 15,127,128,200; done pulse on 4th accept; busy high 9 cycles max.
REQ-034 Load 1,2,3,4 (sorted) -> busy exactly 3 cycles, cmp_count=3, output 1,2,3,4.
REQ-035 Load 4,3,2,1 (reversed) -> busy 9 cycles, cmp_count=9, output 1,2,3,4.
REQ-036 Load 25,25,0,255 (duplicates, extremes) -> output 0,25,25,255; no swap on equal pair.
REQ-037 Hold out_ready=0 for 5 cycles in OUT -> out_valid stays 1, out_data stable at first element; then drain completes normally.
REQ-038 Assert rst during SORT cycle 2 -> next cycle state LOAD, in_ready=1, out_valid=0, cmp_count=0; fresh batch 39,16,79,37 sorts to 16,37,39,79.
